universal_shift_register: RTL

Parametrised universal shift register: successor to the fixed 3-bit SISO right-shift register. Supports hold, right shift, left shift and parallel load under a mode select, with serial and parallel outputs. Adds a burst engine that performs a programmed number of single-bit shifts autonomously, with `busy`/`done` handshake. Used wherever the design needs serialisation/deserialisation or bit-alignment of a word.

---
 rtl/usr_pkg.sv | 20 ++
 rtl/usr_burst_ctrl.sv | 87 ++++++++
 rtl/universal_shift_register.sv | 87 ++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register.
// Mode encodings, burst direction constants and burst FSM states.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst controller: latches a burst request, saturates its length,
// and issues one shift per cycle until done.
// Ports: clk_i, rst_ni (async active-low), start_i/dir_i/cnt_i
// request; busy_o/done_o status; shift_en_o/shift_dir_o to datapath.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          dir_i,
  input  logic [CW-1:0] cnt_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          shift_en_o,
  output logic          shift_dir_o
);

  localparam logic [CW-1:0] WMAX = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = '0;

  state_e        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_sat;

  // Bursts longer than the register would only flush
  // sin through again; clamp to one full width.
  assign cnt_sat = (cnt_i > WMAX) ? WMAX : cnt_i;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          dir_d = dir_i;
          rem_d = cnt_sat;
          // A zero-length burst still completes the
          // handshake so the requester is not left waiting.
          if (cnt_sat == ZERO) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        rem_d = rem_q - ONE;
        if (rem_q == ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      dir_q   <= DIR_R;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign busy_o      = (state_q == ST_SHIFT);
  assign done_o      = done_q;
  assign shift_en_o  = (state_q == ST_SHIFT);
  assign shift_dir_o = dir_q;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold/shift-right/shift-left/load plus
// an autonomous burst shifter. Ports: clk, rst (async active-low),
// en/mode/sin/pin, start/dir/cnt, pout/sout_r/sout_l, busy/done.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic             dir,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             shift_en;
  logic             shift_dir;
  logic             mode_ok;
  logic [WIDTH-1:0] q_shr;
  logic [WIDTH-1:0] q_shl;

  usr_burst_ctrl #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_ctrl (
    .clk_i       (clk),
    .rst_ni      (rst),
    .start_i     (start),
    .dir_i       (dir),
    .cnt_i       (cnt),
    .busy_o      (busy),
    .done_o      (done),
    .shift_en_o  (shift_en),
    .shift_dir_o (shift_dir)
  );

  assign q_shr = {sin, q_q[WIDTH-1:1]};
  assign q_shl = {q_q[WIDTH-2:0], sin};

  // start outranks en in IDLE; mode is ignored while a burst runs.
  assign mode_ok = en && !start && !busy;

  always_comb begin
    q_d = q_q;
    unique case (1'b1)
      shift_en: begin
        q_d = (shift_dir == DIR_L) ? q_shl : q_shr;
      end
      mode_ok: begin
        unique case (mode_e'(mode))
          MODE_HOLD: q_d = q_q;
          MODE_SHR:  q_d = q_shr;
          MODE_SHL:  q_d = q_shl;
          MODE_LOAD: q_d = pin;
          default:   q_d = q_q;
        endcase
      end
      default: begin
        q_d = q_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign pout   = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];

endmodule
